// File: rtl/regfile_scoreboard_if.sv
// Writeback/ID-side bus of the register file scoreboard.
// Latency: n/a (bundle of wires only).
// Backpressure: none; hazard_stall is the only hold mechanism, carried on this bus.
//
// master : pipeline side (drives WB/ID/hazard controls, consumes read data/busy/status)
// slave  : register file side (regfile_scoreboard)
interface regfile_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              hazard_stall;
    logic              hazard_flush;
    logic              WB_RegWrite;
    logic [ADDR_W-1:0] WB_Rd;
    logic [XLEN-1:0]   WB_WriteData;
    logic [31:0]       WB_PC;
    logic [ADDR_W-1:0] ID_Rs1;
    logic [ADDR_W-1:0] ID_Rs2;
    logic              ID_UseRs1;
    logic              ID_UseRs2;
    logic              ID_Issue;
    logic              ID_IssueRegWrite;
    logic [ADDR_W-1:0] ID_IssueRd;
    logic [XLEN-1:0]   ID_ReadData1;
    logic [XLEN-1:0]   ID_ReadData2;
    logic              RF_Busy1;
    logic              RF_Busy2;
    logic              RF_Stall;
    logic [31:0]       RF_RetiredPC;
    logic [31:0]       RF_RetireCount;
    logic              RF_ScoreErr;

    modport master (
        output hazard_stall, hazard_flush,
        output WB_RegWrite, WB_Rd, WB_WriteData, WB_PC,
        output ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2,
        output ID_Issue, ID_IssueRegWrite, ID_IssueRd,
        input  ID_ReadData1, ID_ReadData2, RF_Busy1, RF_Busy2, RF_Stall,
        input  RF_RetiredPC, RF_RetireCount, RF_ScoreErr
    );

    modport slave (
        input  hazard_stall, hazard_flush,
        input  WB_RegWrite, WB_Rd, WB_WriteData, WB_PC,
        input  ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2,
        input  ID_Issue, ID_IssueRegWrite, ID_IssueRd,
        output ID_ReadData1, ID_ReadData2, RF_Busy1, RF_Busy2, RF_Stall,
        output RF_RetiredPC, RF_RetireCount, RF_ScoreErr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with a 2-bit pending-write counter per register and source stall.
// Latency: reads/busy/stall combinational; array, counters, retire PC/count update next cycle.
// Backpressure: none accepted; raises RF_Stall to ID, hazard_stall freezes issue and retire.
//
// Ports: clk, reset (synchronous, active-high), rf (regfile_scoreboard_if.slave) carrying
// the WB write port, ID issue/read ports, hazard controls and retire status.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data to the
// read ports and let a dependent instruction issue in the writeback cycle.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  rf
);

    logic [XLEN-1:0] regs     [NUM_REGS];
    logic [1:0]      cnt      [NUM_REGS];
    logic [1:0]      cnt_nxt  [NUM_REGS];
    logic [31:0]     retired_pc;
    logic [31:0]     retire_count;
    logic            score_err;
    logic            err_set;

    logic            wr;
    logic            iss;
    logic            inc;
    logic            dec;

    // Qualified events: x0 targets and stalled cycles never count.
    assign wr  = rf.WB_RegWrite && !rf.hazard_stall && (rf.WB_Rd != '0);
    assign iss = rf.ID_Issue && rf.ID_IssueRegWrite && !rf.hazard_stall &&
                 (rf.ID_IssueRd != '0);

    // Counter next-state. An issue and a retire to the same register cancel out;
    // saturation at either end holds the count and flags a protocol error.
    always_comb begin
        err_set = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt[i] = cnt[i];
            inc        = iss && (rf.ID_IssueRd == ADDR_W'(i));
            dec        = wr  && (rf.WB_Rd      == ADDR_W'(i));
            if (inc && !dec) begin
                if (cnt[i] == 2'd3) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 2'd1;
                end
            end else if (dec && !inc) begin
                if (cnt[i] == 2'd0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            retired_pc   <= '0;
            retire_count <= '0;
            score_err    <= 1'b0;
        end else begin
            // Retirement is architectural: it commits even in a flush cycle.
            if (wr) begin
                regs[rf.WB_Rd] <= rf.WB_WriteData;
                retired_pc     <= rf.WB_PC;
                retire_count   <= retire_count + 32'd1;
            end
            if (rf.hazard_flush) begin
                // Everything in flight is squashed; a coincident issue is dropped and the
                // error flag is sticky across flushes.
                for (int i = 0; i < NUM_REGS; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    cnt[i] <= cnt_nxt[i];
                end
                if (err_set) begin
                    score_err <= 1'b1;
                end
            end
        end
    end

    // Read ports. x0 is forced to zero and never busy regardless of array contents.
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;
    logic            busy1;
    logic            busy2;

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        busy1    = 1'b0;
        busy2    = 1'b0;
        if (rf.ID_Rs1 != '0) begin
            rd_data1 = regs[rf.ID_Rs1];
            busy1    = (cnt[rf.ID_Rs1] != 2'd0);
`ifdef REGFILE_BYPASS_EN
            // The retiring write is forwarded; the register stays busy only if older
            // writes remain or a new writer issues to it in the same cycle.
            if (wr && (rf.WB_Rd == rf.ID_Rs1)) begin
                rd_data1 = rf.WB_WriteData;
                busy1    = (cnt[rf.ID_Rs1] > 2'd1) || (iss && (rf.ID_IssueRd == rf.ID_Rs1));
            end
`endif
        end
        if (rf.ID_Rs2 != '0) begin
            rd_data2 = regs[rf.ID_Rs2];
            busy2    = (cnt[rf.ID_Rs2] != 2'd0);
`ifdef REGFILE_BYPASS_EN
            if (wr && (rf.WB_Rd == rf.ID_Rs2)) begin
                rd_data2 = rf.WB_WriteData;
                busy2    = (cnt[rf.ID_Rs2] > 2'd1) || (iss && (rf.ID_IssueRd == rf.ID_Rs2));
            end
`endif
        end
    end

    assign rf.ID_ReadData1   = rd_data1;
    assign rf.ID_ReadData2   = rd_data2;
    assign rf.RF_Busy1       = busy1;
    assign rf.RF_Busy2       = busy2;
    assign rf.RF_Stall       = (busy1 && rf.ID_UseRs1) || (busy2 && rf.ID_UseRs2);
    assign rf.RF_RetiredPC   = retired_pc;
    assign rf.RF_RetireCount = retire_count;
    assign rf.RF_ScoreErr    = score_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: table-driven write vectors plus
// hand-written multi-cycle sequences; retired writes are queued and read back later.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .ADDR_W(5)) bus ();

    regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_wr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] exp_data;
        logic        exp_retire;
    } vec_t;

    exp_wr_t     wr_q[$];
    logic [31:0] exp_count;
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.hazard_stall     = 1'b0;
        bus.hazard_flush     = 1'b0;
        bus.WB_RegWrite      = 1'b0;
        bus.WB_Rd            = 5'd0;
        bus.WB_WriteData     = 32'd0;
        bus.WB_PC            = 32'd0;
        bus.ID_Rs1           = 5'd0;
        bus.ID_Rs2           = 5'd0;
        bus.ID_UseRs1        = 1'b0;
        bus.ID_UseRs2        = 1'b0;
        bus.ID_Issue         = 1'b0;
        bus.ID_IssueRegWrite = 1'b0;
        bus.ID_IssueRd       = 5'd0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.ID_Issue         = 1'b1;
        bus.ID_IssueRegWrite = 1'b1;
        bus.ID_IssueRd       = rd;
        tick();
        bus.ID_Issue         = 1'b0;
        bus.ID_IssueRegWrite = 1'b0;
    endtask

    // Drive a writeback and record what the bench expects to read back afterwards.
    task automatic start_retire(input logic [4:0] rd, input logic [31:0] data,
                                input logic [31:0] pc, input logic [31:0] exp_data,
                                input logic exp_ret);
        exp_wr_t e;
        bus.WB_RegWrite  = 1'b1;
        bus.WB_Rd        = rd;
        bus.WB_WriteData = data;
        bus.WB_PC        = pc;
        e.rd   = rd;
        e.data = exp_data;
        wr_q.push_back(e);
        if (exp_ret) begin
            exp_count = exp_count + 32'd1;
            exp_pc    = pc;
        end
    endtask

    task automatic retire(input logic [4:0] rd, input logic [31:0] data,
                          input logic [31:0] pc, input logic [31:0] exp_data,
                          input logic exp_ret);
        start_retire(rd, data, pc, exp_data, exp_ret);
        tick();
        bus.WB_RegWrite = 1'b0;
    endtask

    task automatic check_pop(input string name);
        exp_wr_t e;
        n_cmp++;
        if (wr_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got empty queue expected a pending write", name);
        end else begin
            n_cmp--;
            e = wr_q.pop_front();
            bus.ID_Rs2 = e.rd;
            #1;
            chk(name, bus.ID_ReadData2, e.data);
        end
    endtask

    task automatic chk_status(input string name);
        chk({name, "_count"}, bus.RF_RetireCount, exp_count);
        chk({name, "_pc"}, bus.RF_RetiredPC, exp_pc);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{rd: 5'd1,  data: 32'hA5A5_A5A5, pc: 32'h200, exp_data: 32'hA5A5_A5A5, exp_retire: 1'b1};
        vecs[1] = '{rd: 5'd31, data: 32'hFFFF_FFFF, pc: 32'h204, exp_data: 32'hFFFF_FFFF, exp_retire: 1'b1};
        vecs[2] = '{rd: 5'd0,  data: 32'h0000_1234, pc: 32'h208, exp_data: 32'h0000_0000, exp_retire: 1'b0};
        vecs[3] = '{rd: 5'd10, data: 32'h0000_0000, pc: 32'h20C, exp_data: 32'h0000_0000, exp_retire: 1'b1};
        vecs[4] = '{rd: 5'd2,  data: 32'h1357_9BDF, pc: 32'h210, exp_data: 32'h1357_9BDF, exp_retire: 1'b1};
        vecs[5] = '{rd: 5'd1,  data: 32'h0F0F_0F0F, pc: 32'h214, exp_data: 32'h0F0F_0F0F, exp_retire: 1'b1};

        exp_count = 32'd0;
        exp_pc    = 32'd0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state: every register reads zero and nothing is busy.
        for (int r = 0; r < 32; r++) begin
            bus.ID_Rs1 = 5'(r);
            bus.ID_Rs2 = 5'(31 - r);
            #1;
            chk("rst_rd1", bus.ID_ReadData1, 32'd0);
            chk("rst_rd2", bus.ID_ReadData2, 32'd0);
            chk1("rst_busy1", bus.RF_Busy1, 1'b0);
            chk1("rst_busy2", bus.RF_Busy2, 1'b0);
        end
        chk_status("rst");
        chk1("rst_err", bus.RF_ScoreErr, 1'b0);
        chk1("rst_stall", bus.RF_Stall, 1'b0);
        idle();

        // Issue to x5, retire three cycles later.
        issue(5'd5);
        bus.ID_Rs1    = 5'd5;
        bus.ID_UseRs1 = 1'b1;
        #1;
        chk1("x5_busy", bus.RF_Busy1, 1'b1);
        chk1("x5_stall", bus.RF_Stall, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk1("x5_busy_hold", bus.RF_Busy1, 1'b1);
        end
        tick();
        start_retire(5'd5, 32'hDEAD_BEEF, 32'h100, 32'hDEAD_BEEF, 1'b1);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x5_wbcycle_data", bus.ID_ReadData1, 32'hDEAD_BEEF);
        chk1("x5_wbcycle_busy", bus.RF_Busy1, 1'b0);
        chk1("x5_wbcycle_stall", bus.RF_Stall, 1'b0);
`else
        chk("x5_wbcycle_data", bus.ID_ReadData1, 32'd0);
        chk1("x5_wbcycle_busy", bus.RF_Busy1, 1'b1);
        chk1("x5_wbcycle_stall", bus.RF_Stall, 1'b1);
`endif
        tick();
        bus.WB_RegWrite = 1'b0;
        #1;
        chk("x5_data", bus.ID_ReadData1, 32'hDEAD_BEEF);
        chk1("x5_busy_clr", bus.RF_Busy1, 1'b0);
        chk1("x5_stall_clr", bus.RF_Stall, 1'b0);
        check_pop("x5_q");
        chk_status("x5");
        chk("x5_count_abs", bus.RF_RetireCount, 32'd1);
        chk("x5_pc_abs", bus.RF_RetiredPC, 32'h100);
        idle();

        // Table: issue then retire each vector, read the result back next cycle.
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].rd);
            bus.ID_Rs1 = vecs[v].rd;
            #1;
            chk1("tbl_busy_pre", bus.RF_Busy1, vecs[v].exp_retire);
            retire(vecs[v].rd, vecs[v].data, vecs[v].pc, vecs[v].exp_data, vecs[v].exp_retire);
            #1;
            chk1("tbl_busy_post", bus.RF_Busy1, 1'b0);
            chk("tbl_rd1", bus.ID_ReadData1, vecs[v].exp_data);
            check_pop("tbl_q");
            chk_status("tbl");
            chk1("tbl_err", bus.RF_ScoreErr, 1'b0);
        end
        idle();

        // Saturation: four issues to x7 overflow, three retires drain it.
        for (int k = 0; k < 3; k++) issue(5'd7);
        bus.ID_Rs1 = 5'd7;
        #1;
        chk1("x7_err_before", bus.RF_ScoreErr, 1'b0);
        chk1("x7_busy3", bus.RF_Busy1, 1'b1);
        issue(5'd7);
        chk1("x7_err_ovf", bus.RF_ScoreErr, 1'b1);
        for (int k = 0; k < 3; k++) begin
            retire(5'd7, 32'h70 + 32'(k), 32'h280 + 32'(4 * k), 32'h70 + 32'(k), 1'b1);
            #1;
            chk1("x7_busy_drain", bus.RF_Busy1, (k < 2) ? 1'b1 : 1'b0);
            check_pop("x7_q");
            chk_status("x7");
        end
        chk1("x7_err_sticky", bus.RF_ScoreErr, 1'b1);
        idle();

        // Writeback held by hazard_stall for four cycles retires exactly once.
        issue(5'd9);
        bus.ID_Rs1       = 5'd9;
        bus.hazard_stall = 1'b1;
        bus.WB_RegWrite  = 1'b1;
        bus.WB_Rd        = 5'd9;
        bus.WB_WriteData = 32'h99;
        bus.WB_PC        = 32'h300;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("x9_stall_busy", bus.RF_Busy1, 1'b1);
            chk("x9_stall_data", bus.ID_ReadData1, 32'd0);
            chk_status("x9_stall");
        end
        bus.hazard_stall = 1'b0;
        retire(5'd9, 32'h99, 32'h300, 32'h99, 1'b1);
        #1;
        chk1("x9_busy_clr", bus.RF_Busy1, 1'b0);
        check_pop("x9_q");
        chk_status("x9");
        idle();

        // Flush with two pending on x3, a coincident retire to x4 and issue to x6.
        issue(5'd3);
        issue(5'd3);
        bus.ID_Rs1 = 5'd3;
        #1;
        chk1("x3_busy", bus.RF_Busy1, 1'b1);
        bus.hazard_flush     = 1'b1;
        bus.ID_Issue         = 1'b1;
        bus.ID_IssueRegWrite = 1'b1;
        bus.ID_IssueRd       = 5'd6;
        retire(5'd4, 32'h55, 32'h400, 32'h55, 1'b1);
        idle();
        bus.ID_Rs1 = 5'd3;
        #1;
        chk1("flush_x3_busy", bus.RF_Busy1, 1'b0);
        bus.ID_Rs1 = 5'd6;
        #1;
        chk1("flush_x6_busy", bus.RF_Busy1, 1'b0);
        check_pop("flush_x4_q");
        chk_status("flush");
        chk1("flush_err_kept", bus.RF_ScoreErr, 1'b1);

        // Reset in the middle of activity discards pending state and data.
        issue(5'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 32'd0;
        exp_pc    = 32'd0;
        bus.ID_Rs1 = 5'd12;
        bus.ID_Rs2 = 5'd4;
        #1;
        chk1("rst2_busy", bus.RF_Busy1, 1'b0);
        chk("rst2_x4", bus.ID_ReadData2, 32'd0);
        chk1("rst2_err", bus.RF_ScoreErr, 1'b0);
        chk_status("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
